// File: rtl/cla_addsub_pipe_if.sv
// Operand-issue / writeback bundle for cla_addsub_pipe.
// The slave side is the adder; the master side drives operands and takes results.
interface cla_addsub_pipe_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             in_sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             out_ovf;
   logic             out_zero;

   modport master (
      output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
      input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
   );

   modport slave (
      input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
      output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
   );
endinterface

// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead add/subtract: WIDTH/STAGES bits per stage, group
// carry handed stage-to-stage through registers, whole pipe stalls on backpressure.
module cla4 (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       c_i,
   output logic [3:0] sum_o,
   output logic       gg_o,
   output logic       gp_o
);
   logic [3:0] g, p;
   logic [3:1] c;

   assign g = a_i & b_i;
   assign p = a_i ^ b_i;

   assign c[1] = g[0] | (p[0] & c_i);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_i);

   assign sum_o = p ^ {c, c_i};
   assign gg_o  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
   assign gp_o  = &p;
endmodule

module cla_slice #(
   parameter int SW = 16
) (
   input  logic [SW-1:0] a_i,
   input  logic [SW-1:0] b_i,
   input  logic          c_i,
   output logic [SW-1:0] sum_o,
   output logic          c_o
);
   localparam int NG = SW / 4;

   logic [NG-1:0] gg, gp, gc;

   cla4 u_grp [NG-1:0] (
      .a_i  (a_i),
      .b_i  (b_i),
      .c_i  (gc),
      .sum_o(sum_o),
      .gg_o (gg),
      .gp_o (gp)
   );

   // Group carries from group generate/propagate; c_o doubles as the running carry.
   always_comb begin
      gc  = '0;
      c_o = c_i;
      for (int j = 0; j < NG; j++) begin
         gc[j] = c_o;
         c_o   = gg[j] | (gp[j] & c_o);
      end
   end
endmodule

module cla_addsub_pipe #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input logic               clk,
   input logic               rst_n,
   cla_addsub_pipe_if.slave  bus
);
   localparam int SW = WIDTH / STAGES;

   if (!(STAGES == 1 || STAGES == 2 || STAGES == 4 || STAGES == 8) ||
       (WIDTH % (4 * STAGES)) != 0) begin : g_bad_param
      $error("cla_addsub_pipe: WIDTH must be a multiple of 4*STAGES, STAGES in {1,2,4,8}");
   end

   logic              advance;
   logic [STAGES:0]   vld_pipe;
   logic [STAGES:1]   vld_q;

   assign vld_pipe      = {vld_q, bus.in_valid};
   assign advance       = ~vld_q[STAGES] | bus.out_ready;
   assign bus.in_ready  = advance;
   assign bus.out_valid = vld_q[STAGES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       vld_q <= '0;
      else if (advance) vld_q <= vld_pipe[STAGES-1:0];
   end

   for (genvar k = 0; k < STAGES; k++) begin : stg
      localparam int LO = k * SW;
      localparam int HI = LO + SW;

      logic [WIDTH-1:LO] a_cur, b_cur;
      logic              c_cur;
      logic [SW-1:0]     slice;
      logic [HI-1:0]     s_d, s_q;
      logic              c_d, c_q;

      // Stage 0 folds subtract into the operands; later stages take the skewed copies.
      if (k == 0) begin : g_src
         assign a_cur = bus.in_a;
         assign b_cur = bus.in_sub ? ~bus.in_b : bus.in_b;
         assign c_cur = bus.in_sub | bus.in_cin;
         assign s_d   = slice;
      end else begin : g_src
         assign a_cur = stg[k-1].g_fwd.a_q;
         assign b_cur = stg[k-1].g_fwd.b_q;
         assign c_cur = stg[k-1].c_q;
         assign s_d   = {slice, stg[k-1].s_q};
      end

      cla_slice #(.SW(SW)) u_slice (
         .a_i  (a_cur[LO +: SW]),
         .b_i  (b_cur[LO +: SW]),
         .c_i  (c_cur),
         .sum_o(slice),
         .c_o  (c_d)
      );

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            s_q <= '0;
            c_q <= 1'b0;
         end else if (advance) begin
            s_q <= s_d;
            c_q <= c_d;
         end
      end

      if (k < STAGES - 1) begin : g_fwd
         logic [WIDTH-1:HI] a_q, b_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
            end else if (advance) begin
               a_q <= a_cur[WIDTH-1:HI];
               b_q <= b_cur[WIDTH-1:HI];
            end
         end
      end else begin : g_last
         logic ovf_d, ovf_q, zero_q;

         // Flags are registered with the final slice so they reset to 0 and hold under stall.
         assign ovf_d = (a_cur[WIDTH-1] == b_cur[WIDTH-1]) & (s_d[WIDTH-1] != a_cur[WIDTH-1]);

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ovf_q  <= 1'b0;
               zero_q <= 1'b0;
            end else if (advance) begin
               ovf_q  <= ovf_d;
               zero_q <= ~|s_d;
            end
         end

         assign bus.out_sum  = s_q;
         assign bus.out_cout = c_q;
         assign bus.out_ovf  = ovf_q;
         assign bus.out_zero = zero_q;
      end
   end
endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Bench for cla_addsub_pipe (WIDTH=32, STAGES=2): directed corner beats, backpressure,
// async reset mid-flight, then random traffic against an arithmetic reference model.
module tb_cla_addsub_pipe;
   localparam int W = 32;
   localparam int S = 2;
   localparam longint MAXS = (longint'(1) << (W - 1)) - 1;
   localparam longint MINS = -(longint'(1) << (W - 1));

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      logic         zero;
      int           acc_cyc;
      int           acc_stall;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cla_addsub_pipe_if #(.WIDTH(W)) bus ();
   cla_addsub_pipe #(.WIDTH(W), .STAGES(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   exp_t         q[$];
   int           n_vec = 0;
   int           n_err = 0;
   int           cyc = 0;
   int           stall_cnt = 0;
   logic         hold_vld = 1'b0;
   logic [W+3:0] hold_val = '0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference: plain unsigned/signed arithmetic, no lookahead structure.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic sub);
      exp_t     e;
      longint   sa, sb, res;
      logic [W:0] u;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sub) begin
         res    = sa - sb;
         e.sum  = a - b;
         e.cout = (a >= b);
      end else begin
         res    = sa + sb + longint'(cin);
         u      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
         e.sum  = u[W-1:0];
         e.cout = u[W];
      end
      e.ovf       = (res > MAXS) || (res < MINS);
      e.zero      = (e.sum == '0);
      e.acc_cyc   = 0;
      e.acc_stall = 0;
      return e;
   endfunction

   function automatic logic [W-1:0] rnd_op();
      logic [W-1:0] v;
      case ($urandom_range(0, 6))
         0:       v = '0;
         1:       v = '1;
         2:       v = {1'b1, {(W-1){1'b0}}};
         3:       v = {1'b0, {(W-1){1'b1}}};
         4:       v = W'($urandom_range(0, 7));
         default: v = W'($urandom);
      endcase
      return v;
   endfunction

   // Monitor: samples on the falling edge, between active edges.
   initial begin : mon
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            hold_vld = 1'b0;
         end else begin
            chk("in_ready", 64'(bus.in_ready), 64'(!(bus.out_valid && !bus.out_ready)));
            if (hold_vld)
               chk("stall_hold", 64'({bus.out_valid, bus.out_cout, bus.out_ovf, bus.out_zero, bus.out_sum}),
                   64'(hold_val));
            hold_vld = bus.out_valid && !bus.out_ready;
            if (hold_vld) begin
               hold_val = {bus.out_valid, bus.out_cout, bus.out_ovf, bus.out_zero, bus.out_sum};
               stall_cnt++;
            end
            if (bus.out_valid && bus.out_ready) begin
               if (q.size() == 0) begin
                  chk("spurious_out", 64'(bus.out_valid), 64'(0));
               end else begin
                  e = q.pop_front();
                  chk("sum",  64'(bus.out_sum),  64'(e.sum));
                  chk("cout", 64'(bus.out_cout), 64'(e.cout));
                  chk("ovf",  64'(bus.out_ovf),  64'(e.ovf));
                  chk("zero", 64'(bus.out_zero), 64'(e.zero));
                  if (e.acc_stall == stall_cnt)
                     chk("latency", 64'(cyc - e.acc_cyc), 64'(S));
               end
            end
            if (bus.in_valid && bus.in_ready) begin
               e           = model(bus.in_a, bus.in_b, bus.in_cin, bus.in_sub);
               e.acc_cyc   = cyc;
               e.acc_stall = stall_cnt;
               q.push_back(e);
            end
         end
      end
   end

   // Entered and left just after a rising edge.
   task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub);
      int t = 0;
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_cin   = cin;
      bus.in_sub   = sub;
      do begin
         @(negedge clk);
         t++;
      end while (!bus.in_ready && t < 50);
      if (!bus.in_ready) chk("accept_timeout", 64'(bus.in_ready), 64'(1));
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      while (q.size() != 0 && t < 100) begin
         @(posedge clk);
         t++;
      end
      #1;
      chk("drain_pending", 64'(q.size()), 64'(0));
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : main
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_cin    = 1'b0;
      bus.in_sub    = 1'b0;
      bus.out_ready = 1'b1;

      repeat (2) @(posedge clk);
      #2;
      chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
      chk("rst_out_sum",   64'(bus.out_sum),   64'(0));
      chk("rst_out_cout",  64'(bus.out_cout),  64'(0));
      chk("rst_out_ovf",   64'(bus.out_ovf),   64'(0));
      chk("rst_out_zero",  64'(bus.out_zero),  64'(0));
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic add, carry across the stage boundary and out of the MSB.
      drive(32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0);
      drive(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      drive(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
      drain();

      // Signed overflow and subtract borrow cases; cin must be ignored on subtract.
      drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      drive(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
      drive(32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1);
      drive(32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1);
      drive(32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1);
      drive(32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1);
      drain();

      // Back-to-back stream with a 4-cycle downstream stall in the middle.
      fork
         for (int i = 1; i <= 6; i++) drive(W'(i), W'(i), 1'b0, 1'b0);
         begin
            repeat (3) @(posedge clk);
            #1 bus.out_ready = 1'b0;
            repeat (4) @(posedge clk);
            #1 bus.out_ready = 1'b1;
         end
      join
      drain();

      // Async reset with beats in flight and one held at the output.
      bus.out_ready = 1'b0;
      drive(32'd10, 32'd20, 1'b0, 1'b0);
      drive(32'd30, 32'd40, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      chk("pre_rst_valid", 64'(bus.out_valid), 64'(1));
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(bus.out_valid), 64'(0));
      chk("mid_rst_sum",   64'(bus.out_sum),   64'(0));
      chk("mid_rst_zero",  64'(bus.out_zero),  64'(0));
      q.delete();
      @(posedge clk);
      #3 rst_n = 1'b1;
      bus.out_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("post_rst_valid", 64'(bus.out_valid), 64'(0));

      // Random traffic with random valid/ready.
      for (int i = 0; i < 3000; i++) begin
         bus.in_valid  = ($urandom_range(0, 9) < 7);
         bus.in_a      = rnd_op();
         bus.in_b      = rnd_op();
         bus.in_cin    = 1'($urandom_range(0, 1));
         bus.in_sub    = 1'($urandom_range(0, 1));
         bus.out_ready = ($urandom_range(0, 9) < 7);
         @(posedge clk);
         #1;
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
